// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART transmitter.
// The parity helper is only compiled when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned IDX_W     = $clog2(DATA_BITS);

  // s_TX_PARITY_BIT keeps its code point even in the plain 8N1 build
  typedef enum logic [STATE_W-1:0] {
    s_IDLE          = 3'd0,
    s_TX_START_BIT  = 3'd1,
    s_TX_DATA_BITS  = 3'd2,
    s_TX_PARITY_BIT = 3'd3,
    s_TX_STOP_BIT   = 3'd4
  } tx_state_t;

`ifdef UART_TX_PARITY_EN
  // Even parity is the XOR of the byte; odd parity inverts it
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data,
                                     input logic                 odd);
    return (^data) ^ odd;
  endfunction
`endif

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register: accepts a byte when empty, emptied by the FSM pop.
module uart_tx_hold
  import uart_pkg::*;
(
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 load_valid,
  input  logic [DATA_BITS-1:0] load_byte,
  input  logic                 pop,
  output logic                 hold_full,
  output logic [DATA_BITS-1:0] hold_byte
);

  // Pop only happens while full, so it never races a load
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      hold_full <= 1'b0;
      hold_byte <= '0;
    end else if (pop) begin
      hold_full <= 1'b0;
    end else if (load_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_byte <= load_byte;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, 1 stop bit, back-to-back frames.
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit          PARITY_ODD   = 1'b0
`endif
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] tx_byte;
  logic                 tx_serial;
  logic                 tx_active;
  logic                 tx_done;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_byte;
  logic                 bit_end_c;
  logic                 pop_c;

  assign bit_end_c = (clk_cnt == BIT_LAST);

  // Hold drains when a new frame is launched from idle or straight after a stop bit
  assign pop_c = hold_full &&
                 ((state == s_IDLE) || ((state == s_TX_STOP_BIT) && bit_end_c));

  uart_tx_hold u_hold (
    .i_Clock    (i_Clock),
    .i_Rst_n    (i_Rst_n),
    .load_valid (i_Tx_DV),
    .load_byte  (i_Tx_Byte),
    .pop        (pop_c),
    .hold_full  (hold_full),
    .hold_byte  (hold_byte)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state     <= s_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      tx_byte   <= '0;
      tx_serial <= 1'b1;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        s_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (hold_full) begin
            tx_byte   <= hold_byte;
            tx_serial <= 1'b0;
            tx_active <= 1'b1;
            state     <= s_TX_START_BIT;
          end else begin
            tx_serial <= 1'b1;
            tx_active <= 1'b0;
          end
        end

        s_TX_START_BIT: begin
          if (bit_end_c) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            tx_serial <= tx_byte[0];
            state     <= s_TX_DATA_BITS;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        s_TX_DATA_BITS: begin
          if (bit_end_c) begin
            clk_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              tx_serial <= parity_of(tx_byte, PARITY_ODD);
              state     <= s_TX_PARITY_BIT;
`else
              tx_serial <= 1'b1;
              state     <= s_TX_STOP_BIT;
`endif
            end else begin
              bit_idx   <= bit_idx + IDX_W'(1);
              tx_serial <= tx_byte[bit_idx + IDX_W'(1)];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        s_TX_PARITY_BIT: begin
          if (bit_end_c) begin
            clk_cnt   <= '0;
            tx_serial <= 1'b1;
            state     <= s_TX_STOP_BIT;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
`endif

        // A waiting byte starts its start bit with no idle cycle in between
        s_TX_STOP_BIT: begin
          if (bit_end_c) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            tx_done <= 1'b1;
            if (hold_full) begin
              tx_byte   <= hold_byte;
              tx_serial <= 1'b0;
              state     <= s_TX_START_BIT;
            end else begin
              tx_serial <= 1'b1;
              tx_active <= 1'b0;
              state     <= s_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        default: begin
          state     <= s_IDLE;
          clk_cnt   <= '0;
          bit_idx   <= '0;
          tx_serial <= 1'b1;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

  assign o_Tx_Ready  = !hold_full;
  assign o_Tx_Active = tx_active;
  assign o_Tx_Serial = tx_serial;
  assign o_Tx_Done   = tx_done;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, companion to the existing 8N1 receiver. Serialises bytes as 1 start bit, 8 data bits LSB first, optional parity, and 1 stop bit, on a single clock at CLKS_PER_BIT clocks per bit. A one-entry holding register lets the next byte be accepted while a frame is in flight, so frames go back-to-back with zero idle bits. Sits between the sensor/command logic and the board TX pin.

Parameters:
CLKS_PER_BIT, 87, i_Clock frequency divided by baud rate; legal range 2..65535 (16-bit counter).
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined.

Ports:
i_Clock  input  1  system clock; all logic on its rising edge.
i_Rst_n  input  1  synchronous, active-low reset.
i_Tx_DV  input  1  byte-valid strobe; the byte is accepted on an edge where i_Tx_DV=1 and o_Tx_Ready=1.
i_Tx_Byte  input  8  byte to send; sampled on the accepting edge only.
o_Tx_Ready  output  1  holding register empty; equals !hold_full (combinational from register).
o_Tx_Active  output  1  high while a frame (start through stop) is on the line.
o_Tx_Serial  output  1  serial line, registered, idles high.
o_Tx_Done  output  1  one-cycle pulse at the end of each frame's stop bit.

Behaviour:
- Reset (i_Rst_n=0 at an edge): o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, hold_full=0 (o_Tx_Ready=1), state=s_IDLE, counter=0, bit index=0. Reset wins over i_Tx_DV.
- Reset mid-frame: the frame is abandoned and the line returns high on the reset edge. No o_Tx_Done pulse. Any held byte is discarded.
- Accept: on edge E0 with i_Tx_DV & o_Tx_Ready, capture i_Tx_Byte into hold and set hold_full. i_Tx_DV while o_Tx_Ready=0 is ignored (byte dropped, no error flag).
- States: s_IDLE, s_TX_START_BIT, s_TX_DATA_BITS, s_TX_PARITY_BIT (only with the macro), s_TX_STOP_BIT.
- s_IDLE: serial=1, active=0. If hold_full, on the next edge: load the shift register, clear hold_full, serial<=0, active<=1, counter<=0, go to START. Latency from the accept edge E0 to the start bit is 1 edge (line low after E1).
- Each bit holds its level for exactly CLKS_PER_BIT cycles. The counter runs 0..CLKS_PER_BIT-1. On the terminal count the counter resets to 0 and the next bit's level is registered.
- START to DATA: drive bit 0. DATA: bits 0..7 in order. After bit 7, go to PARITY (macro) or STOP, driving 1 for STOP.
- STOP terminal count: o_Tx_Done<=1 for exactly one cycle.
  - If hold_full: reload, serial<=0, stay active, go to START. There is no idle cycle between frames.
  - Otherwise: serial<=1, active<=0, go to s_IDLE.
- Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- Hold drain and accept never share an edge, because ready is low while hold is full. The byte in hold does not change once captured.
- Illegal or unused state encoding: go to s_IDLE with serial=1 on the next edge.

Optional Feature:
UART_TX_PARITY_EN:
- Defined: s_TX_PARITY_BIT is inserted between data bit 7 and the stop bit, lasting CLKS_PER_BIT cycles. The parity bit is XOR of the byte for even (PARITY_ODD=0) and XNOR for odd (PARITY_ODD=1).
- Undefined: no parity state or logic, plain 8N1, and PARITY_ODD is ignored.

Decomposition:
- Shared package uart_pkg holds:
  - the state encodings (3-bit localparams s_IDLE..s_TX_STOP_BIT, with s_TX_PARITY_BIT reserved even when unused);
  - the DATA_BITS=8 constant;
  - the counter width of 16.
- One natural sub-module, uart_tx_hold: the one-entry holding register. It has a load/valid handshake on its input, a pop strobe from the FSM, and outputs hold_full and hold_byte. The bit-timing counter and FSM stay in uart_tx.

Test Plan:
1. CLKS_PER_BIT=4, send 0xA5 from idle.
   - Line low for 4 cycles starting 1 edge after accept.
   - Then the bit sequence 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles.
   - o_Tx_Done pulses once; 40 cycles total line activity.
2. Send 0x00, then offer 0xFF while 0x00 is at bit 2.
   - o_Tx_Ready drops after the second accept and rises when 0xFF is loaded.
   - The 0xFF start bit follows the 0x00 stop bit with no high cycle between.
   - Two o_Tx_Done pulses, 40 cycles apart.
3. Offer a third byte while hold is full → ignored; only the two earlier bytes appear on the line.
4. Loopback into the existing receiver with CLKS_PER_BIT=87, bytes 0x00, 0x55, 0xAA, 0xFF → the receiver's byte output matches each byte, with one o_Rx_DV per byte.
5. Assert i_Rst_n=0 for 1 cycle during data bit 3.
   - Line is high after the reset edge; ready=1; active=0; no o_Tx_Done.
   - A subsequent 0x3C is sent correctly.
6. With UART_TX_PARITY_EN defined, send 0x07 → parity bit 1 when PARITY_ODD=0 and 0 when PARITY_ODD=1; frame is 44 cycles at CLKS_PER_BIT=4.
